// File: rtl/fxp_div_pkg.sv
// Shared types and constants for the sequential Goldschmidt fixed-point divider.
package fxp_div_pkg;

    localparam int unsigned DIV_N     = 20;
    localparam int unsigned DIV_FRAC  = 10;
    localparam int unsigned DIV_ITER  = 4;
    localparam int unsigned W         = DIV_N + 2;
    localparam int unsigned SAT_MAX   = (1 << (DIV_N - 1)) - 1;
    localparam int unsigned CONST_TWO = 2 << DIV_FRAC;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        MUL_N = 3'd2,
        MUL_D = 3'd3,
        FINAL = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/fxp_mul.sv
// Signed fixed-point multiply, result floor-shifted back to W bits.
module fxp_mul #(
    parameter int unsigned W    = 22,
    parameter int unsigned FRAC = 10
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y_trunc
);

    assign y_trunc = W'(((2*W)'(a) * (2*W)'(b)) >>> FRAC);

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider: normalise the divisor, then run
// Goldschmidt n*f / d*f refinement on a single shared multiplier.
module fxp_div_seq
    import fxp_div_pkg::*;
#(
    parameter int unsigned N    = DIV_N,
    parameter int unsigned FRAC = DIV_FRAC,
    parameter int unsigned ITER = DIV_ITER
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] num,
    input  logic [N-1:0] den,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quot,
    output logic         dbz,
    output logic         ovf
);

    localparam int unsigned WI  = N + 2;
    localparam int unsigned WE  = N + 2 + FRAC;
    localparam int unsigned SAT = (1 << (N - 1)) - 1;
    localparam int unsigned TWO = 2 << FRAC;
    localparam logic [N-1:0] POS_SAT = N'(SAT);
    localparam logic [N-1:0] NEG_SAT = ~POS_SAT + N'(1);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       quot_q, quot_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               sgn_q, sgn_d;
    logic               nsgn_q, nsgn_d;
    logic [WI-1:0]      n_q, n_d;
    logic [WI-1:0]      d_q, d_d;
    logic signed [7:0]  s_q, s_d;
    logic [7:0]         iter_q, iter_d;

    logic [WI-1:0]      f_c;
    logic [WI-1:0]      mul_a;
    logic [WI-1:0]      mul_y;
    logic [7:0]         msb_c;
    logic [7:0]         shamt_c;
    logic [WE-1:0]      mag_c;

    // Magnitude at WI bits so the most negative operand stays exact.
    function automatic logic [WI-1:0] mag_of(input logic [N-1:0] v);
        logic [WI-1:0] ext;
        ext = WI'($signed(v));
        return v[N-1] ? (~ext + WI'(1)) : ext;
    endfunction

    function automatic logic [7:0] lod(input logic [WI-1:0] v);
        logic [7:0] pos;
        pos = '0;
        for (int i = 0; i < int'(WI); i++) begin
            if (v[i]) pos = 8'(i);
        end
        return pos;
    endfunction

    assign f_c = WI'(TWO) - d_q;

    fxp_mul #(.W(WI), .FRAC(FRAC)) u_mul (
        .a       (mul_a),
        .b       (f_c),
        .y_trunc (mul_y)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        sgn_d       = sgn_q;
        nsgn_d      = nsgn_q;
        n_d         = n_q;
        d_d         = d_q;
        s_d         = s_q;
        iter_d      = iter_q;
        mul_a       = n_q;
        msb_c       = '0;
        shamt_c     = '0;
        mag_c       = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sgn_d   = num[N-1] ^ den[N-1];
                    nsgn_d  = num[N-1];
                    n_d     = mag_of(num);
                    d_d     = mag_of(den);
                    iter_d  = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (d_q == '0) begin
                    quot_d      = nsgn_q ? NEG_SAT : POS_SAT;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    // Place the divisor msb at FRAC-1 so d0 lies in [0.5, 1).
                    msb_c = lod(d_q);
                    if (int'(msb_c) >= int'(FRAC) - 1) begin
                        d_d = d_q >> (int'(msb_c) - (int'(FRAC) - 1));
                    end else begin
                        d_d = d_q << ((int'(FRAC) - 1) - int'(msb_c));
                    end
                    s_d     = 8'(int'(FRAC) - 1 - int'(msb_c));
                    state_d = MUL_N;
                end
            end
            MUL_N: begin
                n_d     = mul_y;
                state_d = MUL_D;
            end
            MUL_D: begin
                mul_a   = d_q;
                d_d     = mul_y;
                iter_d  = iter_q + 8'd1;
                state_d = (int'(iter_q) == int'(ITER) - 1) ? FINAL : MUL_N;
            end
            FINAL: begin
                shamt_c = s_q[7] ? 8'(-s_q) : 8'(s_q);
                mag_c   = s_q[7] ? (WE'(n_q) >> shamt_c) : (WE'(n_q) << shamt_c);
                ovf_d   = 1'b0;
                if (mag_c > WE'(SAT)) begin
                    mag_c = WE'(SAT);
                    ovf_d = 1'b1;
                end
                quot_d      = sgn_q ? N'(~mag_c + WE'(1)) : N'(mag_c);
                dbz_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sgn_q       <= 1'b0;
            nsgn_q      <= 1'b0;
            n_q         <= '0;
            d_q         <= '0;
            s_q         <= '0;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            sgn_q       <= sgn_d;
            nsgn_q      <= nsgn_d;
            n_q         <= n_d;
            d_q         <= d_d;
            s_q         <= s_d;
            iter_q      <= iter_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Bench for fxp_div_seq: directed cases against ideal quotients, random jobs
// against an integer Goldschmidt reference, backpressure and mid-job reset.
module tb_fxp_div_seq;

    localparam int N       = 20;
    localparam int FRAC    = 10;
    localparam int ITER    = 4;
    localparam int SAT     = (1 << (N - 1)) - 1;
    localparam int LAT_NOM = 2 * ITER + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] num;
    logic [N-1:0] den;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quot;
    logic         dbz;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fxp_div_seq #(.N(N), .FRAC(FRAC), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint got, input longint exp, input longint tol);
        bit ok;
        ok = (got - exp <= tol) && (exp - got <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, got, exp, tol);
        end
    endtask

    // Divider arithmetic from its defining rules using plain integers.
    function automatic void ref_div(input longint a, input longint b,
                                    output longint q, output bit z, output bit o);
        longint an, ad, n, d, f, mag;
        int msb, s;
        z = 1'b0;
        o = 1'b0;
        if (b == 0) begin
            z = 1'b1;
            q = (a < 0) ? -SAT : SAT;
            return;
        end
        an  = (a < 0) ? -a : a;
        ad  = (b < 0) ? -b : b;
        msb = 0;
        while ((ad >> (msb + 1)) != 0) msb++;
        s = FRAC - 1 - msb;
        d = (s >= 0) ? (ad << s) : (ad >> (-s));
        n = an;
        repeat (ITER) begin
            f = (2 << FRAC) - d;
            n = (n * f) >> FRAC;
            d = (d * f) >> FRAC;
        end
        mag = (s >= 0) ? (n << s) : (n >> (-s));
        if (mag > SAT) begin
            mag = SAT;
            o   = 1'b1;
        end
        q = ((a < 0) != (b < 0)) ? -mag : mag;
    endfunction

    task automatic wait_ready();
        int wt = 0;
        while (in_ready !== 1'b1 && wt < 50) begin
            @(posedge clk); #1;
            wt++;
        end
        chk("in_ready_idle", in_ready, 1);
    endtask

    task automatic run_job(input int a, input int b, output longint q, output bit z,
                           output bit o, output int lat);
        wait_ready();
        num      = N'(a);
        den      = N'(b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        chk("in_ready_busy", in_ready, 0);
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q = longint'($signed(quot));
        z = dbz;
        o = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    task automatic check_job(input string tag, input int a, input int b, input longint exp_q,
                             input longint tol, input bit exp_z, input bit exp_o, input int exp_lat);
        longint q;
        bit z, o;
        int lat;
        run_job(a, b, q, z, o, lat);
        chk_tol({tag, "_quot"}, q, exp_q, tol);
        chk({tag, "_dbz"}, z, exp_z);
        chk({tag, "_ovf"}, o, exp_o);
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        longint mq, q0;
        bit mz, mo;
        int a, b, lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num       = '0;
        den       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", quot, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        check_job("q3_div_1", 3072, 1024, 3072, 1, 1'b0, 1'b0, LAT_NOM);
        check_job("q1_div_3", 1024, 3072, 341, 1, 1'b0, 1'b0, LAT_NOM);
        check_job("neg2_div_half", -2048, 512, -4096, 1, 1'b0, 1'b0, LAT_NOM);
        check_job("dbz_pos", 5, 0, SAT, 0, 1'b1, 1'b0, 2);
        check_job("dbz_neg", -5, 0, -SAT, 0, 1'b1, 1'b0, 2);
        check_job("dbz_zero", 0, 0, SAT, 0, 1'b1, 1'b0, 2);
        check_job("sat_pos", 262144, 1, SAT, 0, 1'b0, 1'b1, LAT_NOM);
        check_job("sat_neg", -262144, 1, -SAT, 0, 1'b0, 1'b1, LAT_NOM);
        check_job("min_num", -(1 << (N - 1)), -(1 << (N - 1)), 1024, 1, 1'b0, 1'b0, LAT_NOM);

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, (1 << N) - 1)) - (1 << (N - 1));
            case ($urandom_range(0, 3))
                0:       b = int'($urandom_range(1, 64));
                1:       b = -int'($urandom_range(1, 4096));
                2:       b = int'($urandom_range(0, (1 << N) - 1)) - (1 << (N - 1));
                default: b = (i % 10 == 3) ? 0 : int'($urandom_range(512, 40000));
            endcase
            if (i % 4 == 1) a = a / 256;
            ref_div(a, b, mq, mz, mo);
            check_job($sformatf("rand%0d", i), a, b, mq, 0, mz, mo, mz ? 2 : LAT_NOM);
        end

        // Hold the result under backpressure while extra requests are offered.
        ref_div(5120, 2048, mq, mz, mo);
        wait_ready();
        num      = N'(5120);
        den      = N'(2048);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, LAT_NOM);
        q0 = longint'($signed(quot));
        chk("bp_quot", q0, mq);
        for (int k = 0; k < 5; k++) begin
            num      = N'(int'($urandom_range(0, 4000)));
            den      = N'(int'($urandom_range(1, 4000)));
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_hold_quot", $signed(quot), q0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_flags", {dbz, ovf}, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        ref_div(7000, -300, mq, mz, mo);
        check_job("bp_next", 7000, -300, mq, 0, mz, mo, LAT_NOM);

        // Abort a job mid-refinement with an asynchronous reset.
        wait_ready();
        num      = N'(3072);
        den      = N'(1024);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_quot", quot, 0);
        chk("arst_dbz", dbz, 0);
        chk("arst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_no_output", out_valid, 0);
        check_job("after_rst", 3072, 1024, 3072, 1, 1'b0, 1'b0, LAT_NOM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
